ps2_key_encoder: RTL and testbench



---
 rtl/ps2_key_encoder.sv | 197 +++++++++++++++++++
 tb/tb_ps2_key_encoder.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_encoder.sv
// PS/2 keyboard receiver: conditions the raw clock/data pair, deframes 11-bit frames
// and folds scancode set 2 prefixes into {toggle, pressed, extended, code}. Macro: PS2KEY_PARITY_CHECK_EN.
module ps2_key_encoder #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 24000
) (
    input  logic        clk_sys,
    input  logic        RESET_N,
    input  logic        ps2_clk_in,
    input  logic        ps2_dat_in,
    output logic [10:0] ps2_key,
    output logic        frame_err,
    output logic        busy
);

    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_LEN - 1);
    localparam logic [FW-1:0] FILT_ONE = FW'(1);
    localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TO_ONE   = TW'(1);

`ifdef PS2KEY_PARITY_CHECK_EN
    // Odd parity over the data byte plus the parity bit.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        odd_parity_ok = ^{data, par};
    endfunction
`endif

    logic          clk_meta_r, clk_sync_r, dat_meta_r, dat_sync_r;
    logic          fclk_r;
    logic [FW-1:0] filt_cnt_r;
    logic          strobe_s;

    logic [3:0]    bit_cnt_r, bit_cnt_nxt_s;
    logic [TW-1:0] to_cnt_r, to_cnt_nxt_s;
    logic [7:0]    shift_r, shift_nxt_s;
    logic          expire_s, err_nxt_s, byte_valid_s, frame_ok_s;
`ifdef PS2KEY_PARITY_CHECK_EN
    logic          par_r, par_nxt_s;
`endif

    logic [10:0]   key_r;
    logic          frame_err_r, busy_r;
    logic          ext_r, brk_r;
    logic [2:0]    skip_r;

    // Synchronizers and clock stability filter; fclk idles high.
    always_ff @(posedge clk_sys) begin
        if (!RESET_N) begin
            clk_meta_r <= 1'b1;
            clk_sync_r <= 1'b1;
            dat_meta_r <= 1'b1;
            dat_sync_r <= 1'b1;
            fclk_r     <= 1'b1;
            filt_cnt_r <= {FW{1'b0}};
        end else begin
            clk_meta_r <= ps2_clk_in;
            clk_sync_r <= clk_meta_r;
            dat_meta_r <= ps2_dat_in;
            dat_sync_r <= dat_meta_r;
            if (clk_sync_r == fclk_r) begin
                filt_cnt_r <= {FW{1'b0}};
            end else if (filt_cnt_r == FILT_MAX) begin
                fclk_r     <= clk_sync_r;
                filt_cnt_r <= {FW{1'b0}};
            end else begin
                filt_cnt_r <= filt_cnt_r + FILT_ONE;
            end
        end
    end

    // Sample strobe fires on the cycle the filtered clock falls.
    always_comb begin
        strobe_s = fclk_r && !clk_sync_r && (filt_cnt_r == FILT_MAX);
    end

    // Stop bit (and, when enabled, odd parity) validation of the completed frame.
    always_comb begin
`ifdef PS2KEY_PARITY_CHECK_EN
        frame_ok_s = dat_sync_r && odd_parity_ok(shift_r, par_r);
`else
        frame_ok_s = dat_sync_r;
`endif
    end

    // Deframer next state; timeout expiry takes priority over a coincident strobe.
    always_comb begin
        bit_cnt_nxt_s = bit_cnt_r;
        to_cnt_nxt_s  = to_cnt_r;
        shift_nxt_s   = shift_r;
`ifdef PS2KEY_PARITY_CHECK_EN
        par_nxt_s     = par_r;
`endif
        err_nxt_s     = 1'b0;
        byte_valid_s  = 1'b0;
        expire_s      = (bit_cnt_r != 4'd0) && (to_cnt_r == TO_MAX);
        if (expire_s) begin
            bit_cnt_nxt_s = 4'd0;
            to_cnt_nxt_s  = {TW{1'b0}};
            err_nxt_s     = 1'b1;
        end else if (strobe_s) begin
            to_cnt_nxt_s = {TW{1'b0}};
            case (bit_cnt_r)
                4'd0: begin
                    if (!dat_sync_r) begin
                        bit_cnt_nxt_s = 4'd1;
                    end else begin
                        bit_cnt_nxt_s = 4'd0;
                    end
                end
                4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8: begin
                    shift_nxt_s   = {dat_sync_r, shift_r[7:1]};
                    bit_cnt_nxt_s = bit_cnt_r + 4'd1;
                end
                4'd9: begin
`ifdef PS2KEY_PARITY_CHECK_EN
                    par_nxt_s     = dat_sync_r;
`endif
                    bit_cnt_nxt_s = 4'd10;
                end
                4'd10: begin
                    bit_cnt_nxt_s = 4'd0;
                    if (frame_ok_s) begin
                        byte_valid_s = 1'b1;
                    end else begin
                        err_nxt_s = 1'b1;
                    end
                end
                default: begin
                    bit_cnt_nxt_s = 4'd0;
                end
            endcase
        end else if (bit_cnt_r != 4'd0) begin
            to_cnt_nxt_s = to_cnt_r + TO_ONE;
        end else begin
            to_cnt_nxt_s = {TW{1'b0}};
        end
    end

    // Deframer state, registered status outputs and the prefix decoder.
    always_ff @(posedge clk_sys) begin
        if (!RESET_N) begin
            bit_cnt_r   <= 4'd0;
            to_cnt_r    <= {TW{1'b0}};
            shift_r     <= 8'h00;
`ifdef PS2KEY_PARITY_CHECK_EN
            par_r       <= 1'b0;
`endif
            frame_err_r <= 1'b0;
            busy_r      <= 1'b0;
            key_r       <= 11'h000;
            ext_r       <= 1'b0;
            brk_r       <= 1'b0;
            skip_r      <= 3'd0;
        end else begin
            bit_cnt_r   <= bit_cnt_nxt_s;
            to_cnt_r    <= to_cnt_nxt_s;
            shift_r     <= shift_nxt_s;
`ifdef PS2KEY_PARITY_CHECK_EN
            par_r       <= par_nxt_s;
`endif
            frame_err_r <= err_nxt_s;
            busy_r      <= (bit_cnt_nxt_s != 4'd0);
            if (byte_valid_s) begin
                if (skip_r != 3'd0) begin
                    skip_r <= skip_r - 3'd1;
                end else begin
                    case (shift_r)
                        8'hE0: ext_r <= 1'b1;
                        8'hF0: brk_r <= 1'b1;
                        // Pause: swallow the remaining 7 bytes of the sequence.
                        8'hE1: begin
                            skip_r <= 3'd7;
                            ext_r  <= 1'b0;
                            brk_r  <= 1'b0;
                        end
                        8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF: begin
                            ext_r <= 1'b0;
                            brk_r <= 1'b0;
                        end
                        default: begin
                            key_r <= {~key_r[10], ~brk_r, ext_r, shift_r};
                            ext_r <= 1'b0;
                            brk_r <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    assign ps2_key   = key_r;
    assign frame_err = frame_err_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_ps2_key_encoder.sv
// Directed bench for ps2_key_encoder: table of frames plus timeout, glitch and reset sequences.
module tb_ps2_key_encoder;

    localparam int FILTER_LEN = 8;
    localparam int TIMEOUT    = 500;

`ifdef PS2KEY_PARITY_CHECK_EN
    localparam logic [10:0] K_PAR  = 11'h21C;
    localparam int          E_PAR  = 1;
    localparam logic [10:0] K_1C   = 11'h61C;
`else
    localparam logic [10:0] K_PAR  = 11'h629;
    localparam int          E_PAR  = 0;
    localparam logic [10:0] K_1C   = 11'h21C;
`endif

    logic        clk_sys = 1'b0;
    logic        RESET_N;
    logic        ps2_clk_in;
    logic        ps2_dat_in;
    logic [10:0] ps2_key;
    logic        frame_err;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int err_seen = 0;

    typedef struct {
        logic [7:0]  code;
        logic        par_bad;
        logic        stop;
        logic [10:0] exp_key;
        int          exp_err;
    } vec_t;

    vec_t vecs[21];

    ps2_key_encoder #(.FILTER_LEN(FILTER_LEN), .TIMEOUT(TIMEOUT)) dut (
        .clk_sys    (clk_sys),
        .RESET_N    (RESET_N),
        .ps2_clk_in (ps2_clk_in),
        .ps2_dat_in (ps2_dat_in),
        .ps2_key    (ps2_key),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) begin
        if (frame_err === 1'b1) err_seen++;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] b, input logic par_bad, input logic stop);
        logic par;
        par = (~^b) ^ par_bad;
        return {stop, par, b, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] fr, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_dat_in = fr[i];
            tick(20);
            ps2_clk_in = 1'b0;
            tick(40);
            ps2_clk_in = 1'b1;
            tick(20);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par_bad, input logic stop);
        send_bits(make_frame(b, par_bad, stop), 11);
        ps2_dat_in = 1'b1;
        tick(40);
    endtask

    initial begin
        int e0;
        vecs[0]  = '{8'h29, 1'b0, 1'b1, 11'h629, 0};
        vecs[1]  = '{8'hE0, 1'b0, 1'b1, 11'h629, 0};
        vecs[2]  = '{8'h75, 1'b0, 1'b1, 11'h375, 0};
        vecs[3]  = '{8'hE0, 1'b0, 1'b1, 11'h375, 0};
        vecs[4]  = '{8'hF0, 1'b0, 1'b1, 11'h375, 0};
        vecs[5]  = '{8'h75, 1'b0, 1'b1, 11'h575, 0};
        vecs[6]  = '{8'hE1, 1'b0, 1'b1, 11'h575, 0};
        vecs[7]  = '{8'h14, 1'b0, 1'b1, 11'h575, 0};
        vecs[8]  = '{8'h77, 1'b0, 1'b1, 11'h575, 0};
        vecs[9]  = '{8'hE1, 1'b0, 1'b1, 11'h575, 0};
        vecs[10] = '{8'hF0, 1'b0, 1'b1, 11'h575, 0};
        vecs[11] = '{8'h14, 1'b0, 1'b1, 11'h575, 0};
        vecs[12] = '{8'hF0, 1'b0, 1'b1, 11'h575, 0};
        vecs[13] = '{8'h77, 1'b0, 1'b1, 11'h575, 0};
        vecs[14] = '{8'h05, 1'b0, 1'b1, 11'h205, 0};
        vecs[15] = '{8'hF0, 1'b0, 1'b1, 11'h205, 0};
        vecs[16] = '{8'hE0, 1'b0, 1'b1, 11'h205, 0};
        vecs[17] = '{8'h6B, 1'b0, 1'b1, 11'h56B, 0};
        vecs[18] = '{8'hE0, 1'b0, 1'b1, 11'h56B, 0};
        vecs[19] = '{8'hFA, 1'b0, 1'b1, 11'h56B, 0};
        vecs[20] = '{8'h1C, 1'b0, 1'b1, 11'h21C, 0};

        RESET_N    = 1'b0;
        ps2_clk_in = 1'b1;
        ps2_dat_in = 1'b1;
        tick(5);
        chk("reset_key", 32'(ps2_key), 32'h000);
        chk("reset_err", 32'(frame_err), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        RESET_N = 1'b1;
        tick(20);

        for (int i = 0; i < 21; i++) begin
            e0 = err_seen;
            send_frame(vecs[i].code, vecs[i].par_bad, vecs[i].stop);
            chk($sformatf("key_row%0d", i), 32'(ps2_key), 32'(vecs[i].exp_key));
            chk($sformatf("err_row%0d", i), 32'(err_seen - e0), 32'(vecs[i].exp_err));
        end

        // Wrong parity on 0x29, then a bad stop bit.
        e0 = err_seen;
        send_frame(8'h29, 1'b1, 1'b1);
        chk("key_badpar", 32'(ps2_key), 32'(K_PAR));
        chk("err_badpar", 32'(err_seen - e0), 32'(E_PAR));
        e0 = err_seen;
        send_frame(8'h33, 1'b0, 1'b0);
        chk("key_badstop", 32'(ps2_key), 32'(K_PAR));
        chk("err_badstop", 32'(err_seen - e0), 32'h1);

        // Partial frame aborted by timeout, then a clean frame.
        e0 = err_seen;
        send_bits(make_frame(8'h1C, 1'b0, 1'b1), 4);
        ps2_dat_in = 1'b1;
        tick(10);
        chk("busy_partial", 32'(busy), 32'h1);
        tick(TIMEOUT + 50);
        chk("err_timeout", 32'(err_seen - e0), 32'h1);
        chk("busy_timeout", 32'(busy), 32'h0);
        chk("key_timeout", 32'(ps2_key), 32'(K_PAR));
        e0 = err_seen;
        send_frame(8'h1C, 1'b0, 1'b1);
        chk("key_after_to", 32'(ps2_key), 32'(K_1C));
        chk("err_after_to", 32'(err_seen - e0), 32'h0);

        // Clock glitches shorter than the filter window.
        e0 = err_seen;
        for (int g = 0; g < 6; g++) begin
            ps2_clk_in = 1'b0;
            tick(FILTER_LEN - 3);
            ps2_clk_in = 1'b1;
            tick(12);
            chk($sformatf("busy_glitch%0d", g), 32'(busy), 32'h0);
        end
        chk("key_glitch", 32'(ps2_key), 32'(K_1C));
        chk("err_glitch", 32'(err_seen - e0), 32'h0);

        // Reset in the middle of a frame.
        e0 = err_seen;
        send_bits(make_frame(8'h5A, 1'b0, 1'b1), 6);
        chk("busy_midframe", 32'(busy), 32'h1);
        RESET_N = 1'b0;
        tick(3);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_key", 32'(ps2_key), 32'h000);
        tick(2);
        RESET_N = 1'b1;
        ps2_dat_in = 1'b1;
        tick(TIMEOUT + 50);
        chk("rst_noerr", 32'(err_seen - e0), 32'h0);
        chk("rst_busy_idle", 32'(busy), 32'h0);
        send_frame(8'h29, 1'b0, 1'b1);
        chk("key_after_rst", 32'(ps2_key), 32'h629);
        chk("err_after_rst", 32'(err_seen - e0), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
